// File: rtl/video_mode_scheduler.sv
// Mode-change sequencer for the HD timing path: holds the active mode table entry and applies
// new modes at a vSync boundary. Optional pattern cycling: VIDEO_MODE_SCHEDULER_PATTERN_CYCLE_EN.
module video_mode_scheduler #(
  parameter int RESET_CYCLES = 16,
  parameter int SETTLE_FRAMES = 2,
`ifdef VIDEO_MODE_SCHEDULER_PATTERN_CYCLE_EN
  parameter int FRAMES_PER_PATTERN = 120,
`endif
  parameter int WATCHDOG_BITS = 22
) (
  input  logic        pixelClock,
  input  logic        resetN,
  input  logic        vSync,
  input  logic [1:0]  modeRequest,
  input  logic        modeRequestValid,
  output logic        modeRequestReady,
  output logic [1:0]  currentMode,
  output logic [6:0]  hFrontPorch,
  output logic [7:0]  hSyncPulse,
  output logic [7:0]  hBackPorch,
  output logic [10:0] hActive,
  output logic [5:0]  vFrontPorch,
  output logic [3:0]  vSyncPulse,
  output logic [5:0]  vBackPorch,
  output logic [10:0] vActive,
  output logic        syncIsActiveLow,
  output logic        isInterlaced,
  output logic [6:0]  videoFormatCode,
  output logic        timingReset,
  output logic        modeReady,
  output logic [1:0]  patternSelect
);

  localparam int RC_W = $clog2(RESET_CYCLES + 1);
  localparam int SF_W = $clog2(SETTLE_FRAMES + 2);

  typedef enum logic [2:0] {LOAD, HOLD, SETTLE, RUN, WAIT_VBLANK} stateT;

  typedef struct packed {
    logic [6:0]  hFp;
    logic [7:0]  hSync;
    logic [7:0]  hBp;
    logic [10:0] hAct;
    logic [5:0]  vFp;
    logic [3:0]  vSync;
    logic [5:0]  vBp;
    logic [10:0] vAct;
    logic        activeLow;
    logic        interlaced;
    logic [6:0]  vic;
  } modeParamsT;

  function automatic modeParamsT lookupMode(input logic [1:0] m);
    modeParamsT p;
    case (m)
      2'd0:    p = '{7'd110, 8'd40, 8'd220, 11'd1280, 6'd5, 4'd5, 6'd20, 11'd720, 1'b0, 1'b0, 7'd4};
      2'd1:    p = '{7'd16, 8'd62, 8'd60, 11'd720, 6'd9, 4'd6, 6'd30, 11'd480, 1'b1, 1'b0, 7'd2};
      2'd2:    p = '{7'd88, 8'd44, 8'd148, 11'd1920, 6'd2, 4'd5, 6'd15, 11'd1080, 1'b0, 1'b1, 7'd5};
      default: p = '{7'd12, 8'd64, 8'd68, 11'd720, 6'd5, 4'd5, 6'd39, 11'd576, 1'b1, 1'b0, 7'd17};
    endcase
    return p;
  endfunction

  stateT                    state, nextState;
  modeParamsT               params;
  logic [1:0]               pendingMode;
  logic                     vSyncPrev;
  logic [RC_W-1:0]          cycleCount;
  logic [SF_W-1:0]          settleCount;
  logic [WATCHDOG_BITS-1:0] wdCount;
  logic [WATCHDOG_BITS-1:0] wdNext;
  logic                     vSyncEdge;
  logic                     holdDone;
  logic                     settleDone;
  logic                     wdTimeout;
  logic                     modeChange;

  // Raw level is sampled every cycle, so a polarity switch in LOAD compares against the
  // true previous level and cannot fabricate an edge.
  assign vSyncEdge  = params.activeLow ? (vSyncPrev & ~vSync) : (~vSyncPrev & vSync);
  assign holdDone   = int'(cycleCount) >= RESET_CYCLES - 1;
  assign settleDone = int'(settleCount) >= SETTLE_FRAMES - 1;
  assign wdNext     = wdCount + 1'b1;
  assign wdTimeout  = &wdNext;
  assign modeChange = modeRequestValid && (modeRequest != currentMode);

  always_comb begin
    nextState = state;
    case (state)
      LOAD:        nextState = HOLD;
      HOLD:        if (holdDone) nextState = (SETTLE_FRAMES == 0) ? RUN : SETTLE;
      SETTLE:      if (vSyncEdge && settleDone) nextState = RUN;
      RUN:         if (modeChange) nextState = WAIT_VBLANK;
      WAIT_VBLANK: if (vSyncEdge || wdTimeout) nextState = LOAD;
      default:     nextState = LOAD;
    endcase
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state       <= LOAD;
      params      <= lookupMode(2'd0);
      pendingMode <= 2'd0;
      currentMode <= 2'd0;
      timingReset <= 1'b1;
      modeReady   <= 1'b0;
      vSyncPrev   <= 1'b0;
      cycleCount  <= '0;
      settleCount <= '0;
      wdCount     <= '0;
    end else begin
      state     <= nextState;
      vSyncPrev <= vSync;
      modeReady <= (nextState == RUN);
      if (nextState == LOAD && state != LOAD) begin
        params      <= lookupMode(pendingMode);
        currentMode <= pendingMode;
        timingReset <= 1'b1;
      end
      case (state)
        LOAD: begin
          // The LOAD cycle itself is the first cycle of the timing-generator reset.
          cycleCount  <= RC_W'(1);
          settleCount <= '0;
          timingReset <= (RESET_CYCLES > 1);
        end
        HOLD: begin
          if (holdDone) timingReset <= 1'b0;
          else          cycleCount  <= cycleCount + 1'b1;
        end
        SETTLE: if (vSyncEdge) settleCount <= settleCount + 1'b1;
        RUN: begin
          if (modeChange) begin
            pendingMode <= modeRequest;
            wdCount     <= '0;
          end
        end
        WAIT_VBLANK: wdCount <= wdNext;
        default: ;
      endcase
    end
  end

  assign modeRequestReady = (state == RUN);
  assign hFrontPorch      = params.hFp;
  assign hSyncPulse       = params.hSync;
  assign hBackPorch       = params.hBp;
  assign hActive          = params.hAct;
  assign vFrontPorch      = params.vFp;
  assign vSyncPulse       = params.vSync;
  assign vBackPorch       = params.vBp;
  assign vActive          = params.vAct;
  assign syncIsActiveLow  = params.activeLow;
  assign isInterlaced     = params.interlaced;
  assign videoFormatCode  = params.vic;

`ifdef VIDEO_MODE_SCHEDULER_PATTERN_CYCLE_EN
  localparam int FP_W = $clog2(FRAMES_PER_PATTERN + 1);

  logic [FP_W-1:0] frameCount;
  logic [1:0]      patternReg;

  // Frames are only counted while the mode is stable; the pattern index survives mode changes.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      frameCount <= '0;
      patternReg <= 2'd0;
    end else if (state == RUN) begin
      if (vSyncEdge) begin
        if (int'(frameCount) >= FRAMES_PER_PATTERN - 1) begin
          frameCount <= '0;
          patternReg <= patternReg + 1'b1;
        end else begin
          frameCount <= frameCount + 1'b1;
        end
      end
    end else begin
      frameCount <= '0;
    end
  end

  assign patternSelect = patternReg;
`else
  assign patternSelect = 2'd0;
`endif

endmodule

// File: doc/video_mode_scheduler.md
Name: video_mode_scheduler

Overview:
- Configuration sequencer for the HD timing path (VideoFormatTiming → ColorBars720p → HdmiEncoder).
- Holds the active video mode's timing parameters, sync polarity, interlace flag and HDMI video format code (VIC).
- Accepts mode-change requests over a valid/ready handshake and applies them only at a vertical sync boundary. It holds the timing generator in reset while the new parameters settle, then reports the mode as ready after a fixed number of clean frames.

Parameters:
RESET_CYCLES, 16, cycles timingReset is held high after a parameter load (min 1)
SETTLE_FRAMES, 2, vSync leading edges counted after reset release before modeReady (0 allowed)
WATCHDOG_BITS, 22, width of the vSync-wait timeout counter; timeout = 2^WATCHDOG_BITS-1 cycles
FRAMES_PER_PATTERN, 120, frames per pattern step (only with the optional feature)

Ports:
pixelClock  in  1  pixel clock; all logic on its rising edge
resetN  in  1  asynchronous, active-low reset
vSync  in  1  vSync from the timing generator, in the current mode's polarity
modeRequest  in  2  requested mode: 0=720p60, 1=480p60, 2=1080i60, 3=576p50
modeRequestValid  in  1  request strobe
modeRequestReady  out  1  request accepted when valid&&ready
currentMode  out  2  mode whose parameters are being driven
hFrontPorch  out  7  timing parameter
hSyncPulse  out  8  timing parameter
hBackPorch  out  8  timing parameter
hActive  out  11  timing parameter
vFrontPorch  out  6  timing parameter
vSyncPulse  out  4  timing parameter
vBackPorch  out  6  timing parameter
vActive  out  11  timing parameter
syncIsActiveLow  out  1  sync polarity for the timing generator and encoder
isInterlaced  out  1  interlace flag
videoFormatCode  out  7  VIC for the HDMI AVI infoframe
timingReset  out  1  active-high reset to the timing generator
modeReady  out  1  current mode stable
patternSelect  out  2  test-pattern index (optional feature)

Behaviour:
- Mode table, in order hFP/hSync/hBP/hAct/vFP/vSync/vBP/vAct/activeLow/interlaced/VIC:
  - mode 0: 110/40/220/1280/5/5/20/720/0/0/4
  - mode 1: 16/62/60/720/9/6/30/480/1/0/2
  - mode 2: 88/44/148/1920/2/5/15/1080/0/1/5
  - mode 3: 12/64/68/720/5/5/39/576/1/0/17
- All table outputs are registered and change only on entering LOAD.
- vSync leading edge:
  - Registered previous sample; edge = transition into the asserted level.
  - Asserted level = high when syncIsActiveLow=0, low when 1.
  - The sample register reloads from the current level in LOAD, so no false edge is seen on a polarity change.
- Reset values:
  - state=LOAD, currentMode=0, mode 0 parameters.
  - timingReset=1, modeReady=0, modeRequestReady=0, patternSelect=0.
  - All counters 0.
- FSM states: LOAD, HOLD, SETTLE, RUN, WAIT_VBLANK.
  - LOAD (1 cycle): drive the pendingMode parameters, set currentMode=pendingMode, timingReset=1 → HOLD.
  - HOLD: timingReset=1 for RESET_CYCLES cycles counted from LOAD entry, then timingReset=0. Next state is SETTLE, or RUN if SETTLE_FRAMES=0.
  - SETTLE: count vSync edges; on the SETTLE_FRAMES-th edge → RUN. No timeout; a missing vSync keeps modeReady=0.
  - RUN: modeReady=1, modeRequestReady=1.
    - On accept with modeRequest==currentMode: no-op, stay in RUN.
    - Otherwise: latch pendingMode, set modeReady=0 and modeRequestReady=0 on the next cycle → WAIT_VBLANK.
  - WAIT_VBLANK: modeRequestReady=0; requests are ignored, not queued.
    - On a vSync edge → LOAD on the next cycle.
    - If the watchdog counter saturates first → LOAD, so a dead timing generator cannot wedge the block.
    - The watchdog clears on WAIT_VBLANK entry.
- Total latency from an accept to timingReset=1 is the vSync wait + 1 cycle.
- modeRequestReady is combinational from state (RUN only); modeReady is registered.
- resetN assertion at any time, including mid-sequence, returns all outputs to their reset values immediately. After release the block runs LOAD → HOLD → SETTLE for mode 0.

Optional Feature:
- Macro: VIDEO_MODE_SCHEDULER_PATTERN_CYCLE_EN.
- Defined:
  - A frame counter counts vSync edges while in RUN.
  - At FRAMES_PER_PATTERN it clears and patternSelect increments, wrapping 3→0.
  - The counter clears on leaving RUN; patternSelect holds its value across mode changes.
- Undefined: patternSelect is tied to 0 and no frame counter is instantiated.

Test Plan:
1. Reset release, vSync toggling at mode 0 polarity → timingReset high exactly 16 cycles, modeReady=1 on the 2nd vSync rising edge, outputs 1280/720/VIC 4.
2. In RUN, request mode 1 → ready drops, no parameter change until the next vSync rising edge. The cycle after that edge: hActive=720, vActive=480, syncIsActiveLow=1, VIC 2, timingReset=1.
3. After switching to mode 1, drive vSync active-low → modeReady only after 2 falling edges; no spurious edge at the polarity change.
4. Request mode 2 with vSync held static, WATCHDOG_BITS=6 → LOAD after 63 cycles, isInterlaced=1, VIC 5.
5. Request current mode (0) → accepted for one cycle, no timingReset, modeReady stays 1. Pulse resetN low mid-HOLD of a mode-3 change → outputs return to mode 0 values asynchronously.
6. With the macro defined and FRAMES_PER_PATTERN=3, 13 vSync edges in RUN → patternSelect steps 0,1,2,3,0 at edges 3,6,9,12.
